pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the MIPS core. Holds the architectural PC register.
//  Issues word fetches to instruction memory over a valid/ready request channel.
//  Presents {pc, instr} to decode through a one-entry output register.
//  Next PC comes from add_basic_pc (PC+4) or from a redirect (branch/jump/exception).
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  ADDR_W        32             PC / instruction-address width
//  INSTR_W       32             instruction width
// PORTS
//  clk             in   1        single clock, rising edge
//  rst_n           in   1        asynchronous, active-low reset
//  redirect_valid  in   1        load redirect_pc this cycle, flush fetch
//  redirect_pc     in   ADDR_W   branch/jump target
//  imem_req_valid  out  1        fetch request valid
//  imem_req_ready  in   1        memory accepts request
//  imem_addr       out  ADDR_W   fetch address (word aligned)
//  imem_rsp_valid  in   1        response data valid (exactly one per accepted req)
//  imem_rsp_data   in   INSTR_W  fetched instruction
//  if_valid        out  1        decode-side output valid
//  if_ready        in   1        decode accepts output
//  if_pc           out  ADDR_W   PC of presented instruction
//  if_instr        out  INSTR_W  presented instruction
//  if_fault        out  1        misaligned-target flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc_q=RESET_VECTOR, state=FETCH
//   - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0, if_fault=0
//  imem_req_valid is registered; it first rises the cycle after rst_n deasserts.
//  FSM states:
//   - FETCH: req_valid=1, imem_addr=pc_q.
//     - req_ready=1 -> WAIT. req_valid and addr hold stable until accepted.
//   - WAIT: on rsp_valid:
//     - if_instr<=rsp_data, if_pc<=pc_q, if_valid<=1.
//     - pc_q<=pc_q+4 via add_basic_pc(inp2=4, enb=advance).
//     - -> FETCH if the output slot frees this cycle (if_valid=0 or if_ready=1), else HOLD.
//   - HOLD: req_valid=0. if_ready=1 -> FETCH.
//   - DRAIN: discard the next rsp_valid, then -> FETCH.
//  Output slot: if_valid falls on if_ready unless refilled in the same cycle. Min issue interval 2 cycles.
//  Redirect (highest priority, any state):
//   - pc_q<={redirect_pc[31:2],2'b00}; if_valid<=0 (flush).
//   - From FETCH/HOLD -> FETCH.
//   - From FETCH with req_ready=1 in the same cycle: the request is already accepted -> DRAIN.
//   - From WAIT without rsp_valid -> DRAIN.
//   - Redirect with rsp_valid in the same cycle: response dropped -> FETCH.
//   - Redirect in DRAIN: new pc loaded, stay DRAIN.
//  Wrap-around: pc_q=32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
//  pc_q never advances without a delivered instruction. Stall = if_ready low.
// CONFIGURATION
//  Macro PC_ALIGN_CHECK_EN:
//   - Defined: redirect_pc[1:0]!=0 sets a sticky fault bit. The next delivered instruction has if_fault=1.
//     The bit clears on delivery or on a new aligned redirect.
//   - Undefined: low bits are silently cleared and if_fault is tied to 0.
// STRUCTURE
//  Package mips_fetch_pkg:
//   - fetch_state_t enum {FETCH, WAIT, HOLD, DRAIN}
//   - INSTR_BYTES=4, MIPS_NOP=32'h0000_0000
//  One sub-module: add_basic_pc (PC+4 incrementer). All else inline: FSM, pc_q, output register.
// TESTING
//  - Reset, mem always ready, 1-cycle rsp, if_ready=1 -> if_pc=0,4,8,12 with matching instrs, no gaps beyond the 2-cycle interval.
//  - if_ready=0 for 5 cycles after the first delivery -> if_pc=0 held stable, no new req, resumes with addr=4.
//  - Redirect to 32'h0000_0100 while in WAIT -> in-flight rsp dropped; next if_pc=32'h100, no 0x4 seen.
//  - Redirect coinciding with rsp_valid -> rsp discarded, imem_addr=target next cycle.
//  - pc_q preset via redirect to 32'hFFFF_FFFC -> delivered pcs FFFF_FFFC then 0000_0000.
//  - PC_ALIGN_CHECK_EN on: redirect to 32'h0000_0102 -> if_pc=32'h100, if_fault=1 once; off -> if_fault=0.
//  - rst_n pulsed low while in WAIT -> outputs reset immediately; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: fetch-stage state encoding and instruction constants shared by the fetch RTL
package mips_fetch_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_unit_add_basic_pc.sv
// add_basic_pc: PC incrementer, returns inp1+inp2 when enb is set and inp1 unchanged otherwise
module add_basic_pc #(
  parameter int W = 32
) (
  input  logic [W-1:0] inp1,
  input  logic [W-1:0] inp2,
  input  logic         enb,
  output logic [W-1:0] sum
);
  assign sum = enb ? inp1 + inp2 : inp1;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS fetch stage (PC register, imem request FSM, decode output slot); PC_ALIGN_CHECK_EN enables if_fault on misaligned redirects
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_fault
);
  fetch_state_t       state, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_inc, target;
  logic [INSTR_W-1:0] hold_instr;
  logic               accept, slot_free, deliver;
  assign imem_addr = pc_q;
  assign accept    = imem_req_valid && imem_req_ready;
  assign slot_free = !if_valid || if_ready;
  assign target    = {redirect_pc[ADDR_W-1:2], 2'b00};
  // an instruction enters the output slot straight from memory, or from the parked copy once decode drains the slot
  assign deliver   = !redirect_valid && ((state == WAIT && imem_rsp_valid && slot_free) || (state == HOLD && if_ready));
  add_basic_pc #(.W(ADDR_W)) u_add (
    .inp1 (pc_q),
    .inp2 (ADDR_W'(INSTR_BYTES)),
    .enb  (deliver),
    .sum  (pc_inc)
  );
  // next state: a redirect flushes, and an already accepted request has its response drained
  always_comb
    case (state)
      FETCH:   state_d = accept ? (redirect_valid ? DRAIN : WAIT) : FETCH;
      WAIT:    state_d = imem_rsp_valid ? (redirect_valid || slot_free ? FETCH : HOLD) : (redirect_valid ? DRAIN : WAIT);
      HOLD:    state_d = redirect_valid || if_ready ? FETCH : HOLD;
      default: state_d = imem_rsp_valid ? FETCH : DRAIN;
    endcase
  // FSM state, PC, registered request strobe and the decode-side output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= FETCH;
      pc_q           <= RESET_VECTOR;
      imem_req_valid <= 1'b0;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_instr       <= INSTR_W'(MIPS_NOP);
      hold_instr     <= '0;
    end else begin
      state          <= state_d;
      imem_req_valid <= state_d == FETCH;
      pc_q           <= redirect_valid ? target : pc_inc;
      if_valid       <= !redirect_valid && (deliver || (if_valid && !if_ready));
      if (state == WAIT && imem_rsp_valid) hold_instr <= imem_rsp_data;
      if (deliver) begin
        if_pc    <= pc_q;
        if_instr <= state == HOLD ? hold_instr : imem_rsp_data;
      end
    end
`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;
  // sticky misaligned-target flag, handed to the next delivered instruction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fault_q  <= 1'b0;
      if_fault <= 1'b0;
    end else begin
      fault_q <= redirect_valid ? |redirect_pc[1:0] : fault_q && !deliver;
      if (deliver) if_fault <= fault_q;
    end
`else
  logic unused_low;
  assign unused_low = ^redirect_pc[1:0];
  assign if_fault   = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized fetch-stage bench with an in-order instruction-stream reference model
module tb_pc_fetch_unit;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic        clk = 0, rst_n = 0;
  logic        redirect_valid = 0, imem_req_ready = 0, imem_rsp_valid = 0, if_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic        imem_req_valid, if_valid, if_fault;
  logic [31:0] imem_addr, if_pc, if_instr;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk = 0, n_fail = 0, cyc = 0, idle = 0;
  int p_rdy = 100, p_ifr = 100, lat_lo = 1, lat_hi = 1, p_redir = 0;
  bit rd_req = 0;
  logic [31:0] rd_target = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_pc = 0, h_pc = 0, h_instr = 0, pr_addr = 0;
  bit          exp_fault = 0, held = 0, flushed = 0, pr_req = 0;
  logic        h_fault = 0;
  logic [31:0] dlv_pc[$], dlv_instr[$];
  logic        dlv_fault[$];
  int          dlv_cyc[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    redirect_valid = 0; imem_req_ready = 0; imem_rsp_valid = 0; if_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_if_valid", if_valid, 0);
    chk("reset_if_pc", if_pc, 0);
    chk("reset_if_instr", if_instr, 0);
    chk("reset_if_fault", if_fault, 0);
    mq_addr.delete(); mq_due.delete();
    dlv_pc.delete(); dlv_instr.delete(); dlv_fault.delete(); dlv_cyc.delete();
    exp_pc = 0; exp_fault = 0; held = 0; flushed = 0; pr_req = 0; cyc = 0; idle = 0; rd_req = 0;
    p_rdy = 100; p_ifr = 100; lat_lo = 1; lat_hi = 1; p_redir = 0;
    rst_n = 1;
  endtask

  // one clock: check presented outputs, act as memory and decode, then advance the stream model
  task automatic step();
    bit red, acc;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    idle++;
    if (flushed) chk("flush_valid", if_valid, 0);
    else if (held) begin
      chk("hold_valid", if_valid, 1);
      chk("hold_pc", if_pc, h_pc);
      chk("hold_instr", if_instr, h_instr);
      chk("hold_fault", if_fault, h_fault);
    end else if (if_valid === 1'b1) begin
      chk("dlv_pc", if_pc, exp_pc);
      chk("dlv_instr", if_instr, mem_data(exp_pc));
      chk("dlv_fault", if_fault, exp_fault);
      dlv_pc.push_back(if_pc); dlv_instr.push_back(if_instr);
      dlv_fault.push_back(if_fault); dlv_cyc.push_back(cyc);
      exp_pc += 4; exp_fault = 0; idle = 0;
    end
    if (idle > 100) begin
      chk("progress_timeout", idle, 0);
      idle = 0;
    end
    if (pr_req) begin
      chk("req_held_valid", imem_req_valid, 1);
      chk("req_held_addr", imem_addr, pr_addr);
    end
    if (imem_req_valid) begin
      chk("req_addr", imem_addr, exp_pc);
      chk("req_outstanding", mq_addr.size(), 0);
    end
    red = rd_req || (int'($urandom_range(99)) < p_redir);
    tgt = rd_req ? rd_target : ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom);
    rd_req = 0;
    imem_rsp_valid = mq_addr.size() > 0 && mq_due[0] <= cyc;
    imem_rsp_data = imem_rsp_valid ? mem_data(mq_addr[0]) : $urandom;
    if (imem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    imem_req_ready = int'($urandom_range(99)) < p_rdy;
    if_ready = int'($urandom_range(99)) < p_ifr;
    redirect_valid = red;
    redirect_pc = tgt;
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
    end
    pr_req = imem_req_valid && !imem_req_ready && !red;
    pr_addr = imem_addr;
    if (red) begin
      flushed = 1; held = 0; idle = 0;
      exp_pc = {tgt[31:2], 2'b00};
      exp_fault = ALIGN && (tgt[1:0] != 2'b00);
    end else begin
      flushed = 0;
      held = if_valid && !if_ready;
      h_pc = if_pc; h_instr = if_instr; h_fault = if_fault;
    end
  endtask

  task automatic wait_dlv(input int n, input string name);
    for (int i = 0; i < 200 && dlv_pc.size() < n; i++) step();
    chk(name, dlv_pc.size() >= n, 1);
  endtask

  initial begin
    // back-to-back stream, memory always ready, 1-cycle response
    do_reset();
    wait_dlv(4, "stream_count");
    chk("stream_pc0", dlv_pc[0], 32'h0);
    chk("stream_pc1", dlv_pc[1], 32'h4);
    chk("stream_pc2", dlv_pc[2], 32'h8);
    chk("stream_pc3", dlv_pc[3], 32'hC);
    chk("stream_instr0", dlv_instr[0], 32'h5A5A_0F0F);
    chk("stream_instr1", dlv_instr[1], 32'h2287_E9CB);
    chk("stream_first_cycle", dlv_cyc[0], 3);
    for (int k = 1; k < 4; k++) chk("stream_interval", dlv_cyc[k] - dlv_cyc[k-1], 2);

    // decode stalls after the first delivery
    do_reset();
    p_ifr = 0;
    wait_dlv(1, "stall_first");
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_if_pc", if_pc, 32'h0);
    end
    chk("stall_no_req", imem_req_valid, 0);
    p_ifr = 100;
    wait_dlv(2, "stall_resume");
    chk("stall_resume_pc", dlv_pc[1], 32'h4);

    // redirect while waiting on memory
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && mq_addr.size() == 0; i++) step();
    rd_req = 1; rd_target = 32'h0000_0100;
    step();
    lat_lo = 1; lat_hi = 1;
    wait_dlv(1, "redir_wait_dlv");
    chk("redir_wait_pc", dlv_pc[0], 32'h0000_0100);

    // redirect in the same cycle as the response
    do_reset();
    for (int i = 0; i < 20 && mq_addr.size() == 0; i++) step();
    rd_req = 1; rd_target = 32'h0000_0200;
    step();
    step();
    chk("redir_rsp_req_valid", imem_req_valid, 1);
    chk("redir_rsp_addr", imem_addr, 32'h0000_0200);
    wait_dlv(1, "redir_rsp_dlv");
    chk("redir_rsp_pc", dlv_pc[0], 32'h0000_0200);

    // PC wrap-around
    do_reset();
    rd_req = 1; rd_target = 32'hFFFF_FFFC;
    wait_dlv(2, "wrap_dlv");
    chk("wrap_pc0", dlv_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", dlv_pc[1], 32'h0000_0000);

    // misaligned redirect target
    do_reset();
    rd_req = 1; rd_target = 32'h0000_0102;
    wait_dlv(2, "fault_dlv");
    chk("fault_pc", dlv_pc[0], 32'h0000_0100);
    chk("fault_flag", dlv_fault[0], ALIGN);
    chk("fault_cleared", dlv_fault[1], 0);

    // asynchronous reset while a fetch is outstanding and the slot is full
    do_reset();
    p_ifr = 0; lat_lo = 3; lat_hi = 3;
    rd_req = 1; rd_target = 32'h0000_0300;
    wait_dlv(1, "arst_pre_dlv");
    @(posedge clk);
    #2;
    chk("arst_pre_valid", if_valid, 1);
    rst_n = 0;
    #1;
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_if_valid", if_valid, 0);
    chk("arst_if_pc", if_pc, 0);
    chk("arst_if_instr", if_instr, 0);
    do_reset();
    step();
    chk("arst_restart_req", imem_req_valid, 1);
    chk("arst_restart_addr", imem_addr, 32'h0);
    wait_dlv(1, "arst_restart_dlv");
    chk("arst_restart_pc", dlv_pc[0], 32'h0);

    // randomized traffic
    do_reset();
    p_rdy = 60; p_ifr = 70; lat_lo = 1; lat_hi = 4; p_redir = 3;
    for (int i = 0; i < 3000; i++) step();
    chk("random_progress", dlv_pc.size() > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
